// File: rtl/shift_pkg.sv
// ============================================================================
// Module : shift_pkg
// Types and constants shared by the shifter link transmitter and receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic {IDLE, SHIFT} rx_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_s_to_p_rx_if.sv
// ============================================================================
// Module : shift_s_to_p_rx_if
// Serial input and parallel handshake bundle of the serial-to-parallel receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface shift_s_to_p_rx_if #(
    parameter int WIDTH = shift_pkg::DEFAULT_WIDTH
);
    logic             sIn;
    logic             enable;
    logic             frame;
    logic             ready;
    logic             clrOvr;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             overrun;
    logic             busy;

    // master = link/consumer side that drives the stream and ready
    modport master (
        output sIn, enable, frame, ready, clrOvr,
        input  data, valid, overrun, busy
    );

    // slave = the receiver itself
    modport slave (
        input  sIn, enable, frame, ready, clrOvr,
        output data, valid, overrun, busy
    );
endinterface : shift_s_to_p_rx_if

`default_nettype wire

// File: rtl/shift_s_to_p_rx_bit_counter.sv
// ============================================================================
// Module : rx_bit_counter
// Bit counter for the receiver: clear, load-1, increment, terminal at WIDTH-1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rx_bit_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic load1_i,
    input  wire logic inc_i,
    input  wire logic clr_i,
    output logic      term_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CW'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == CW'(WIDTH - 1));

endmodule : rx_bit_counter

`default_nettype wire

// File: rtl/shift_s_to_p_rx.sv
// ============================================================================
// Module : shift_s_to_p_rx
// MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_s_to_p_rx
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    shift_s_to_p_rx_if.slave   bus
);
    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic             cnt_load1, cnt_inc, cnt_clr, cnt_term;
    logic             word_done;
    logic [WIDTH-1:0] shifted;

    assign shifted = {sr_q[WIDTH-2:0], bus.sIn};

    rx_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .term_o  (cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        word_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable && bus.frame) begin
                    sr_d      = shifted;
                    cnt_load1 = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.enable) begin
                    sr_d = shifted;
                    if (bus.frame) begin
                        // resync: the partial word is abandoned silently
                        cnt_load1 = 1'b1;
                    end else if (!cnt_term) begin
                        cnt_inc = 1'b1;
                    end else begin
                        word_done = 1'b1;
                        cnt_clr   = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (bus.clrOvr) begin
            overrun_d = 1'b0;
        end
        if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || bus.ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.data    = data_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (state_q == SHIFT);

endmodule : shift_s_to_p_rx

`default_nettype wire

// File: tb/tb_shift_s_to_p_rx.sv
// ============================================================================
// Module : tb_shift_s_to_p_rx
// Directed and random stimulus against a bit-queue reference of the receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shift_s_to_p_rx;
    import shift_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_s_to_p_rx_if #(.WIDTH(W)) bus ();

    shift_s_to_p_rx #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: bits of the word in progress, plus the output buffer
    bit           m_bits[$];
    bit           m_inprog;
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_ovr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_inprog = 0;
        m_data   = '0;
        m_valid  = 0;
        m_ovr    = 0;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".data"},    32'(bus.data),    32'(m_data));
        check_val({tag, ".valid"},   32'(bus.valid),   32'(m_valid));
        check_val({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
        check_val({tag, ".busy"},    32'(bus.busy),    32'(m_inprog));
    endtask

    // apply inputs for one cycle, predict, clock, then compare
    task automatic step(input bit s, input bit en, input bit fr, input bit rdy, input bit clr);
        bit           done;
        logic [W-1:0] word;
        bus.sIn    = s;
        bus.enable = en;
        bus.frame  = fr;
        bus.ready  = rdy;
        bus.clrOvr = clr;
        done = 0;
        word = '0;
        if (en) begin
            if (fr) begin
                m_bits.delete();
                m_bits.push_back(s);
                m_inprog = 1;
            end else if (m_inprog) begin
                m_bits.push_back(s);
                if (m_bits.size() == W) begin
                    foreach (m_bits[i]) word = (word << 1) | W'(m_bits[i]);
                    m_bits.delete();
                    m_inprog = 0;
                    done = 1;
                end
            end
        end
        if (clr) m_ovr = 0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    task automatic idle_cycle(input bit rdy, input bit clr);
        step(1'b0, 1'b0, 1'b0, rdy, clr);
    endtask

    // send a word MSB-first; optional enable gaps; ready_last applies to the LSB cycle
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last, input bit gaps);
        for (int i = W - 1; i >= 0; i--) begin
            step(w[i], 1'b1, (i == W - 1), (i == 0) ? rdy_last : rdy, 1'b0);
            if (gaps && i != 0) step(1'b1, 1'b0, 1'b1, rdy, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.sIn = 0; bus.enable = 0; bus.frame = 0; bus.ready = 0; bus.clrOvr = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("reset");

        // basic word
        send_word(8'hA5, 1'b1, 1'b1, 1'b0);
        check_val("basic.data", 32'(bus.data), 32'h0000_00A5);
        idle_cycle(1'b1, 1'b0);
        check_val("basic.valid_drop", 32'(bus.valid), 32'd0);

        // back-to-back
        send_word(8'h3C, 1'b1, 1'b1, 1'b0);
        check_val("b2b.first", 32'(bus.data), 32'h0000_003C);
        send_word(8'hC3, 1'b1, 1'b1, 1'b0);
        check_val("b2b.second", 32'(bus.data), 32'h0000_00C3);
        idle_cycle(1'b1, 1'b0);

        // overrun
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        check_val("ovr.data", 32'(bus.data), 32'h0000_0011);
        check_val("ovr.flag", 32'(bus.overrun), 32'd1);
        idle_cycle(1'b1, 1'b0);
        check_val("ovr.sticky", 32'(bus.overrun), 32'd1);
        idle_cycle(1'b0, 1'b1);
        check_val("ovr.clear", 32'(bus.overrun), 32'd0);

        // stray bits, resync, gapped enable
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("stray.valid", 32'(bus.valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b1, 1'b1);
        check_val("resync.data", 32'(bus.data), 32'h0000_005A);
        check_val("resync.valid", 32'(bus.valid), 32'd1);
        idle_cycle(1'b1, 1'b0);

        // completion and ready on the same edge, with set-vs-clear collision later
        send_word(8'h81, 1'b0, 1'b0, 1'b0);
        send_word(8'h7E, 1'b0, 1'b1, 1'b0);
        check_val("simul.data", 32'(bus.data), 32'h0000_007E);
        check_val("simul.valid", 32'(bus.valid), 32'd1);
        check_val("simul.ovr", 32'(bus.overrun), 32'd0);
        for (int i = W - 1; i >= 0; i--)
            step(i[0] ^ 1'b1, 1'b1, (i == W - 1), 1'b0, (i == 0));
        check_val("setwins.ovr", 32'(bus.overrun), 32'd1);
        idle_cycle(1'b1, 1'b1);

        // asynchronous reset mid-word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(8'h0F, 1'b1, 1'b1, 1'b0);
        check_val("post_rst.data", 32'(bus.data), 32'h0000_000F);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(11) == 0),
                 ($urandom_range(2) != 0), ($urandom_range(15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_s_to_p_rx

`default_nettype wire

// File: doc/shift_s_to_p_rx.md
# shift_s_to_p_rx

Serial-to-parallel receiver that is the far end of the existing parallel-to-serial shifter link. It samples a 1-bit MSB-first stream under a frame marker and a bit-enable qualifier, and assembles WIDTH-bit words. Each completed word is presented on a registered parallel output with a valid/ready handshake and sticky overrun reporting. It sits between the serial link and the consuming datapath register or bus.

## Interface
- WIDTH, 8, word length in bits; legal range WIDTH >= 2
- Clock  in  1  single clock; all state updates on posedge
- Reset_n  in  1  asynchronous, active-low reset
- sIn  in  1  serial data, MSB first; sampled only when enable=1
- enable  in  1  bit-valid qualifier; sIn is ignored when 0
- frame  in  1  high with enable on the cycle the MSB of a word is presented
- ready  in  1  consumer accepts data when valid && ready
- clrOvr  in  1  synchronous clear of overrun
- data  out  WIDTH  last completed word, registered
- valid  out  1  data holds an unconsumed word
- overrun  out  1  sticky; a completed word was dropped
- busy  out  1  a partial word is being assembled (state SHIFT)

## Operation
- States: IDLE, SHIFT. Internal: shift register sr[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH+1).
- Sampled bit means a posedge with enable=1. Shift rule: sr <= {sr[WIDTH-2:0], sIn}.
- IDLE: if enable && frame, shift in the bit, set cnt=1, and go to SHIFT. Otherwise hold, including when enable=1 and frame=0. Stray bits are discarded.
- SHIFT, enable=0: hold sr, cnt and state.
- SHIFT, enable && frame: resync. Discard the partial word, shift in the bit, set cnt=1, stay in SHIFT. No flag is raised.
- SHIFT, enable && !frame && cnt<WIDTH-1: shift in the bit and increment cnt.
- SHIFT, enable && !frame && cnt==WIDTH-1: this is the completing bit.
  - The word {sr[WIDTH-2:0], sIn} completes. Go to IDLE with cnt=0.
  - If valid==0, or valid && ready on this edge: data <= word and valid <= 1.
  - Otherwise (valid && !ready): data is unchanged, the word is dropped, and overrun <= 1.
- Handshake: valid stays high until an edge with ready=1. On that edge valid falls, unless a new word completes on the same edge, in which case valid stays 1 and data takes the new word.
- overrun: set as above. Cleared by clrOvr=1. If set and clear happen on the same edge, set wins.
- busy = (state==SHIFT).

## Timing
- Reset values: data=0, valid=0, overrun=0, busy=0, state=IDLE, cnt=0, sr=0. Reset takes effect immediately on Reset_n falling, not on a clock edge.
- Reset mid-word discards the partial word. The first framed bit after Reset_n rises starts a fresh word.
- Latency: data and valid update on the same edge that samples the last bit (LSB). WIDTH sampled bits yield one word.
- Zero-gap streaming: a framed MSB may arrive on the cycle right after the completing bit, since IDLE accepts frame immediately. Sustained throughput is one word per WIDTH enabled cycles.
- ready has no combinational path to any output. All outputs are registered.

## Structure
- Shared package shift_pkg holds:
  - typedef enum logic {IDLE, SHIFT} rx_state_t
  - localparam DEFAULT_WIDTH = 8, also used by the transmitter
- Optional sub-module rx_bit_counter: parameterised counter with load-1, increment, clear, and a terminal flag at WIDTH-1. The FSM, shift register and output buffer stay in shift_s_to_p_rx.

## Test plan
- Basic word: ready=1, send 0xA5 MSB-first with frame on the first bit and enable=1 throughout.
  - busy is high for bits 1–7.
  - data=0xA5 and valid=1 for exactly one cycle after the 8th edge.
- Back-to-back: ready=1, send 0x3C then 0xC3 with no gap.
  - valid pulses after edge 8 (data=0x3C) and after edge 16 (data=0xC3).
- Overrun: ready=0, send 0x11 then 0x22.
  - data=0x11, valid=1, overrun=1.
  - Then ready=1 for one cycle: valid=0 and overrun stays 1.
  - Then clrOvr=1: overrun=0.
- Resync and qualifier: send 3 bits of 0xFF, then a fresh frame of 0x5A with enable toggling 1/0 every cycle.
  - Exactly one word is delivered, data=0x5A.
  - Stray bits sent in IDLE without frame produce nothing.
- Simultaneous events: hold valid with 0x81 and ready=0. Raise ready on the same edge that completes 0x7E.
  - Result: data=0x7E, valid=1, overrun=0.
- Reset mid-word: pull Reset_n low after 4 bits of 0xF0.
  - Immediately: data=0, valid=0, busy=0, overrun=0.
  - After release, a framed 0x0F is received correctly.
